// File: rtl/foc_loop_sequencer.sv
// Per-PWM-period scheduler for the FOC loops: ADC trigger, then speed/d/q PI enable
// pulses in cascade order with settle gaps, plus overrun and ADC-timeout flags.
module foc_loop_sequencer #(
   parameter int SPEED_DIV_WIDTH = 8,
   parameter int SETTLE_CYCLES   = 2,
   parameter int ADC_TIMEOUT     = 255
) (
   input  logic                       i_clk,
   input  logic                       i_nrst,
   input  logic                       i_enable,
   input  logic                       i_pwm_sync,
   output logic                       o_adc_start,
   input  logic                       i_adc_valid,
   input  logic [SPEED_DIV_WIDTH-1:0] i_speed_div,
   output logic                       o_en_spd,
   output logic                       o_en_d,
   output logic                       o_en_q,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_overrun,
   output logic                       o_adc_timeout,
   input  logic                       i_flags_clr
);

   localparam int WAIT_W   = $clog2(ADC_TIMEOUT + 1);
   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_ADC,
      ST_RUN_SPD,
      ST_RUN_D,
      ST_RUN_Q,
      ST_SETTLE,
      ST_DONE
   } state_t;

   state_t                     r_state;
   state_t                     r_after;
   logic [WAIT_W-1:0]          r_wait_cnt;
   logic [SETTLE_W-1:0]        r_settle_cnt;
   logic [SPEED_DIV_WIDTH-1:0] r_div_cnt;
   logic                       r_adc_start;
   logic                       r_en_spd;
   logic                       r_en_d;
   logic                       r_en_q;
   logic                       r_done;
   logic                       r_overrun;
   logic                       r_adc_timeout;

   logic w_overrun_set;
   logic w_wait_expired;
   logic w_timeout_set;
   logic w_settle_last;

   assign w_overrun_set  = i_pwm_sync && (r_state != ST_IDLE);
   assign w_wait_expired = (r_wait_cnt == WAIT_W'(ADC_TIMEOUT - 1));
   assign w_timeout_set  = (r_state == ST_WAIT_ADC) && !i_adc_valid && w_wait_expired;
   assign w_settle_last  = (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));

   // Pulse outputs are registered alongside the state so each one lines up with its state.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state       <= ST_IDLE;
         r_after       <= ST_IDLE;
         r_wait_cnt    <= '0;
         r_settle_cnt  <= '0;
         r_div_cnt     <= '0;
         r_adc_start   <= 1'b0;
         r_en_spd      <= 1'b0;
         r_en_d        <= 1'b0;
         r_en_q        <= 1'b0;
         r_done        <= 1'b0;
         r_overrun     <= 1'b0;
         r_adc_timeout <= 1'b0;
      end else begin
         r_adc_start <= 1'b0;
         r_en_spd    <= 1'b0;
         r_en_d      <= 1'b0;
         r_en_q      <= 1'b0;
         r_done      <= 1'b0;

         if (w_overrun_set)
            r_overrun <= 1'b1;
         else if (i_flags_clr)
            r_overrun <= 1'b0;

         if (w_timeout_set)
            r_adc_timeout <= 1'b1;
         else if (i_flags_clr)
            r_adc_timeout <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (i_pwm_sync && i_enable) begin
                  r_state     <= ST_WAIT_ADC;
                  r_wait_cnt  <= '0;
                  r_adc_start <= 1'b1;
               end
            end
            ST_WAIT_ADC: begin
               if (i_adc_valid) begin
                  if (r_div_cnt == '0) begin
                     r_state  <= ST_RUN_SPD;
                     r_en_spd <= 1'b1;
                  end else begin
                     r_state <= ST_RUN_D;
                     r_en_d  <= 1'b1;
                  end
               end else if (w_wait_expired) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ST_RUN_SPD: begin
               r_state      <= ST_SETTLE;
               r_after      <= ST_RUN_D;
               r_settle_cnt <= '0;
            end
            ST_RUN_D: begin
               r_state      <= ST_SETTLE;
               r_after      <= ST_RUN_Q;
               r_settle_cnt <= '0;
            end
            ST_RUN_Q: begin
               r_state      <= ST_SETTLE;
               r_after      <= ST_DONE;
               r_settle_cnt <= '0;
            end
            ST_SETTLE: begin
               if (w_settle_last) begin
                  r_state <= r_after;
                  case (r_after)
                     ST_RUN_D: r_en_d  <= 1'b1;
                     ST_RUN_Q: r_en_q  <= 1'b1;
                     ST_DONE:  r_done  <= 1'b1;
                     default:  r_state <= ST_IDLE;
                  endcase
               end else begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               // >= rather than == so a shrinking divider cannot strand the count above it
               if (r_div_cnt >= i_speed_div)
                  r_div_cnt <= '0;
               else
                  r_div_cnt <= r_div_cnt + 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_adc_start   = r_adc_start;
   assign o_en_spd      = r_en_spd;
   assign o_en_d        = r_en_d;
   assign o_en_q        = r_en_q;
   assign o_done        = r_done;
   assign o_busy        = (r_state != ST_IDLE);
   assign o_overrun     = r_overrun;
   assign o_adc_timeout = r_adc_timeout;

endmodule

// File: tb/tb_foc_loop_sequencer.sv
// Scoreboard bench for foc_loop_sequencer: stimulus queues expected pulse events,
// a negedge monitor pops and compares them whenever the DUT emits a pulse.
module tb_foc_loop_sequencer;

   localparam logic [4:0] EV_ADC  = 5'b10000;
   localparam logic [4:0] EV_SPD  = 5'b01000;
   localparam logic [4:0] EV_D    = 5'b00100;
   localparam logic [4:0] EV_Q    = 5'b00010;
   localparam logic [4:0] EV_DONE = 5'b00001;

   logic       clk;
   logic       nrst;
   logic       enable;
   logic       pwmSync;
   logic       adcStart;
   logic       adcValid;
   logic [7:0] speedDiv;
   logic       enSpd;
   logic       enD;
   logic       enQ;
   logic       busy;
   logic       done;
   logic       overrun;
   logic       adcTimeout;
   logic       flagsClr;

   typedef struct {
      int         cyc;
      logic [4:0] ev;
   } exp_t;

   exp_t       sbQ[$];
   exp_t       monExp;
   logic [4:0] monEv;
   int         cyc;
   int         nTests;
   int         nFail;

   foc_loop_sequencer #(
      .SPEED_DIV_WIDTH(8),
      .SETTLE_CYCLES  (2),
      .ADC_TIMEOUT    (16)
   ) dut (
      .i_clk        (clk),
      .i_nrst       (nrst),
      .i_enable     (enable),
      .i_pwm_sync   (pwmSync),
      .o_adc_start  (adcStart),
      .i_adc_valid  (adcValid),
      .i_speed_div  (speedDiv),
      .o_en_spd     (enSpd),
      .o_en_d       (enD),
      .o_en_q       (enQ),
      .o_busy       (busy),
      .o_done       (done),
      .o_overrun    (overrun),
      .o_adc_timeout(adcTimeout),
      .i_flags_clr  (flagsClr)
   );

   // Free-running clock and a cycle index that names "cycle c" as the span after the c-th edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void pushExp(input int c, input logic [4:0] e);
      exp_t t;
      t.cyc = c;
      t.ev  = e;
      sbQ.push_back(t);
   endfunction

   // Monitor: any overdue expectation is a missed pulse; any pulse must match the queue head.
   always @(negedge clk) begin
      monEv = {adcStart, enSpd, enD, enQ, done};
      while (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
         monExp = sbQ.pop_front();
         nTests++;
         nFail++;
         $display("[TB] FAIL missedEvent: got none at cycle %0d, expected event %b", monExp.cyc, monExp.ev);
      end
      if (monEv != 5'b0) begin
         nTests++;
         if ($countones(monEv) != 1) begin
            nFail++;
            $display("[TB] FAIL oneHot: got %b at cycle %0d, expected a single pulse", monEv, cyc);
         end
         nTests++;
         if (sbQ.size() == 0 || sbQ[0].cyc != cyc) begin
            nFail++;
            $display("[TB] FAIL unexpectedEvent: got %b at cycle %0d, expected no pulse", monEv, cyc);
         end else begin
            monExp = sbQ.pop_front();
            if (monExp.ev != monEv) begin
               nFail++;
               $display("[TB] FAIL eventKind: got %b at cycle %0d, expected %b", monEv, cyc, monExp.ev);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // One full sequence; extra pwm/clear pulses are placed at offsets from the adc_valid cycle k.
   task automatic applyStimulus(input int validDelay, input bit spdDue, input int xPwmA,
                                input int xPwmB, input int clrAt, input bit dropEn);
      int c0;
      int k;
      int doneCyc;
      c0 = cyc;
      pwmSync = 1'b1;
      tick();
      pwmSync = 1'b0;
      pushExp(c0 + 1, EV_ADC);
      if (dropEn) enable = 1'b0;
      repeat (validDelay) tick();
      k = cyc;
      checkOutput("busyWaitAdc", {31'b0, busy}, 32'd1);
      adcValid = 1'b1;
      if (spdDue) begin
         pushExp(k + 1,  EV_SPD);
         pushExp(k + 4,  EV_D);
         pushExp(k + 7,  EV_Q);
         pushExp(k + 10, EV_DONE);
         doneCyc = k + 10;
      end else begin
         pushExp(k + 1, EV_D);
         pushExp(k + 4, EV_Q);
         pushExp(k + 7, EV_DONE);
         doneCyc = k + 7;
      end
      while (cyc <= doneCyc) begin
         tick();
         adcValid = 1'b0;
         pwmSync  = (xPwmA != 0 && cyc == k + xPwmA) || (xPwmB != 0 && cyc == k + xPwmB);
         flagsClr = (clrAt != 0 && cyc == k + clrAt);
      end
      checkOutput("idleAfterDone", {31'b0, busy}, 32'd0);
      enable = 1'b1;
   endtask

   initial begin
      int c0;
      int k;
      nTests   = 0;
      nFail    = 0;
      nrst     = 1'b1;
      enable   = 1'b1;
      pwmSync  = 1'b0;
      adcValid = 1'b0;
      speedDiv = 8'd0;
      flagsClr = 1'b0;
      #1 nrst = 1'b0;
      tick();
      tick();
      checkOutput("resetOutputs", {24'b0, adcStart, enSpd, enD, enQ, done, busy, overrun, adcTimeout}, 32'h0);
      nrst = 1'b1;
      tick();

      $display("[TB] basic sequence, speed_div=0");
      applyStimulus(4, 1'b1, 0, 0, 0, 1'b0);

      $display("[TB] divider, speed_div=2, six sequences");
      speedDiv = 8'd2;
      applyStimulus(0, 1'b1, 0, 0, 0, 1'b0);
      applyStimulus(1, 1'b0, 0, 0, 0, 1'b0);
      applyStimulus(2, 1'b0, 0, 0, 0, 1'b0);
      applyStimulus(3, 1'b1, 0, 0, 0, 1'b0);
      applyStimulus(0, 1'b0, 0, 0, 0, 1'b0);
      applyStimulus(5, 1'b0, 0, 0, 0, 1'b0);

      $display("[TB] adc timeout");
      c0 = cyc;
      pwmSync = 1'b1;
      tick();
      pwmSync = 1'b0;
      pushExp(c0 + 1, EV_ADC);
      repeat (15) tick();
      checkOutput("timeoutLastWait", {30'b0, busy, adcTimeout}, 32'h2);
      tick();
      checkOutput("timeoutIdle", {30'b0, busy, adcTimeout}, 32'h1);
      flagsClr = 1'b1;
      tick();
      flagsClr = 1'b0;
      checkOutput("timeoutCleared", {31'b0, adcTimeout}, 32'd0);

      $display("[TB] valid on the last wait cycle, speed loop still due");
      applyStimulus(15, 1'b1, 0, 0, 0, 1'b0);
      checkOutput("noTimeoutOnValid", {31'b0, adcTimeout}, 32'd0);

      $display("[TB] overrun during SETTLE and DONE");
      checkOutput("overrunClearBefore", {31'b0, overrun}, 32'd0);
      applyStimulus(0, 1'b0, 2, 7, 0, 1'b0);
      checkOutput("overrunSet", {31'b0, overrun}, 32'd1);
      flagsClr = 1'b1;
      tick();
      flagsClr = 1'b0;
      checkOutput("overrunCleared", {31'b0, overrun}, 32'd0);
      applyStimulus(1, 1'b0, 7, 0, 7, 1'b0);
      checkOutput("overrunSetBeatsClear", {31'b0, overrun}, 32'd1);

      $display("[TB] enable gating");
      flagsClr = 1'b1;
      tick();
      flagsClr = 1'b0;
      enable  = 1'b0;
      pwmSync = 1'b1;
      tick();
      pwmSync = 1'b0;
      repeat (3) tick();
      checkOutput("gatedIdle", {30'b0, busy, overrun}, 32'h0);
      enable = 1'b1;
      applyStimulus(2, 1'b1, 0, 0, 0, 1'b1);

      $display("[TB] async reset during SETTLE");
      c0 = cyc;
      pwmSync = 1'b1;
      tick();
      pwmSync = 1'b0;
      pushExp(c0 + 1, EV_ADC);
      k = cyc;
      adcValid = 1'b1;
      pushExp(k + 1, EV_D);
      tick();
      adcValid = 1'b0;
      pwmSync  = 1'b1;
      tick();
      pwmSync = 1'b0;
      checkOutput("preResetState", {30'b0, busy, overrun}, 32'h3);
      #2 nrst = 1'b0;
      #1 checkOutput("asyncResetOutputs", {24'b0, adcStart, enSpd, enD, enQ, done, busy, overrun, adcTimeout}, 32'h0);
      tick();
      tick();
      nrst = 1'b1;
      repeat (6) tick();
      applyStimulus(1, 1'b1, 0, 0, 0, 1'b0);

      repeat (5) tick();
      checkOutput("scoreboardEmpty", sbQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/foc_loop_sequencer.md
# foc_loop_sequencer

Per-PWM-period scheduler for the FOC control loops. It waits for the PWM synchronisation pulse, triggers an ADC conversion, and waits for the sample. It then issues single-cycle enable pulses, in cascade order, to the speed PI controller (every N-th period) and the d-axis and q-axis current PI controllers. After each pulse it inserts settle gaps so each controller's combinational output and the saturated feedback stabilise before the next loop consumes them.

## Interface
Parameters:
- `SPEED_DIV_WIDTH`, 8: width of the speed-loop divider input.
- `SETTLE_CYCLES`, 2: idle cycles after each enable pulse, ≥1.
- `ADC_TIMEOUT`, 255: maximum cycles spent waiting for `adc_valid`, ≥1.

Ports:
- `clk`, in, 1: system clock.
- `nrst`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: permits new sequences. Sampled only in IDLE.
- `pwm_sync`, in, 1: single-cycle PWM-centre pulse that starts a sequence.
- `adc_start`, out, 1: single-cycle ADC trigger.
- `adc_valid`, in, 1: ADC sample ready. Ignored outside WAIT_ADC.
- `speed_div`, in, `SPEED_DIV_WIDTH`: the speed loop runs once every `speed_div`+1 sequences.
- `en_spd`, out, 1: speed PI enable pulse.
- `en_d`, out, 1: d-axis current PI enable pulse.
- `en_q`, out, 1: q-axis current PI enable pulse.
- `busy`, out, 1: high while not in IDLE.
- `done`, out, 1: single-cycle pulse when a sequence completes.
- `overrun`, out, 1: sticky flag; `pwm_sync` arrived while busy.
- `adc_timeout`, out, 1: sticky flag; ADC did not respond.
- `flags_clr`, in, 1: clears both sticky flags.

## Operation
States are IDLE, WAIT_ADC, RUN_SPD, RUN_D, RUN_Q, SETTLE and DONE. SETTLE tracks which state follows it.

Sequence:
- IDLE → WAIT_ADC when `pwm_sync && enable`. `adc_start` pulses on the first WAIT_ADC cycle.
- WAIT_ADC → RUN_SPD when `adc_valid` and the speed loop is due; otherwise → RUN_D.
- WAIT_ADC → IDLE when the wait counter reaches `ADC_TIMEOUT` without `adc_valid`. This sets `adc_timeout`, emits no enable pulses and no `done`, and leaves the divider counter unchanged.
- Each RUN_x state lasts one cycle with its `en_x` high, then enters SETTLE for `SETTLE_CYCLES` cycles.
- Order is RUN_SPD → RUN_D → RUN_Q → DONE. The speed loop runs first because it produces the iq reference.
- DONE lasts one cycle with `done`=1, then → IDLE.

Speed divider:
- `div_cnt` resets to 0. The speed loop is due when `div_cnt`==0.
- On each `done`: if `div_cnt` ≥ `speed_div`, `div_cnt` ← 0; otherwise `div_cnt` ← `div_cnt`+1. The ≥ compare keeps behaviour safe when `speed_div` shrinks mid-count.
- `speed_div`=0 means the speed loop runs every sequence.

Boundary conditions:
- `pwm_sync` in any non-IDLE state, including DONE, sets `overrun`. The pulse is otherwise ignored.
- `pwm_sync` in IDLE with `enable`=0 is ignored and does not set `overrun`.
- `flags_clr` and a set event in the same cycle: set wins.
- `enable` deasserted mid-sequence: the sequence completes normally.
- `adc_valid` on the same cycle the timeout count is reached: valid wins and the sequence proceeds.
- At most one of `en_spd`, `en_d`, `en_q`, `done`, `adc_start` is high in any cycle.

## Timing
- Reset: all outputs 0, state IDLE, `div_cnt`=0, wait counter 0. Reset asserted mid-sequence aborts immediately with no further pulses.
- Start: `pwm_sync` sampled at cycle 0 → `adc_start` and `busy` high at cycle 1.
- `adc_valid` sampled high at cycle k. With S=`SETTLE_CYCLES`:
  - Speed loop not due: `en_d` at k+1, `en_q` at k+2+S, `done` at k+3+2S, IDLE at k+4+2S.
  - Speed loop due: `en_spd` at k+1, and every later event shifts by 1+S.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Timeout: `adc_timeout` is set and the state returns to IDLE on the cycle after the `ADC_TIMEOUT`-th WAIT_ADC cycle.

## Test plan
All scenarios use S=2 and `ADC_TIMEOUT`=16.
- Basic sequence: reset, `speed_div`=0, `pwm_sync` at cycle 0, `adc_valid` at cycle 5 → `adc_start` at 1, `en_spd` at 6, `en_d` at 9, `en_q` at 12, `done` at 15.
- Divider: `speed_div`=2, six sequences → `en_spd` only in sequences 1 and 4. Each sequence without the speed loop has `en_d` at k+1 and `done` at k+7.
- Timeout: `adc_valid` held low → `adc_timeout`=1 and state IDLE after 16 wait cycles, no enable pulses, no `done`. The next sequence still runs the speed loop (`div_cnt` unchanged).
- Overrun: `pwm_sync` during SETTLE and again during DONE → `overrun`=1, sequence timing unchanged. `flags_clr` concurrent with a new overrun → `overrun` stays 1.
- Gating: `enable`=0 with `pwm_sync` in IDLE → no `adc_start`, `overrun`=0. `enable` dropped after `adc_start` → sequence completes with `done`.
- Async reset: `nrst` low during SETTLE after `en_d` → all outputs 0 immediately and no `en_q`. After release, a new `pwm_sync` runs the speed loop (`div_cnt`=0).
